sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port sequencer sharing the board's single 16-bit asynchronous SRAM between the SLC-3 CPU memory path (MAR/MDR) and the program loader / debug port. It arbitrates round-robin, runs a fixed-length SRAM access with correctly ordered active-low strobes, and returns a one-cycle acknowledge with captured read data. It sits between the CPU datapath and the top-level SRAM pins (CE, UB, LB, OE, WE, ADDR, Data).

## Interface
- ADDR_W, 20, SRAM address width; requester addresses are zero-extended into it.
- WAIT_CYCLES, 2, number of ACCESS cycles per transaction; legal range 1..15.

- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  16  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data; valid from the cpu_ack cycle, held until the next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_ack: same as the cpu_* ports, for the loader.
- CE, UB, LB, OE, WE  out  1 each  active-low SRAM strobes.
- ADDR  out  ADDR_W  SRAM address.
- Data_out  out  16  write data to the pad tristate.
- Data_oe  out  1  1 = pad drives Data_out.
- Data_in  in  16  pad read data.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: samples requests. If any request is high, latches the winner's id, we, addr and wdata, then goes to ACCESS.
  - ACCESS: lasts WAIT_CYCLES cycles, counted by a wait counter loaded with WAIT_CYCLES-1.
  - DONE: one cycle, then always returns to IDLE.
- Arbitration:
  - One request only: that requester wins.
  - Both requests: the requester not granted last wins.
  - `last` resets to loader, so the CPU wins the first tie.
- Strobes:
  - CE, UB, LB are low during ACCESS and DONE, and high otherwise.
  - OE is low during ACCESS only, and only for reads.
  - WE is low during ACCESS only, and only for writes.
  - OE and WE are never low together.
- Data path:
  - Data_oe is high during ACCESS and DONE for writes, giving one cycle of hold after WE rises.
  - Data_out is the latched wdata.
  - Read data is registered from Data_in on the last ACCESS edge into the winner's rdata register. The other port's rdata is unchanged.
- Address: ADDR is the latched address, zero-extended. It is held through ACCESS and DONE and keeps its last value in IDLE.
- Acknowledge: the winner's ack is high for exactly the DONE cycle.
- Requests are sampled only in IDLE. Requests that change during ACCESS or DONE are ignored until the next IDLE.

## Timing
- Reset asserted, asynchronously, at any point, including mid-access:
  - state = IDLE, counter = 0, last = loader.
  - CE = UB = LB = OE = WE = 1, Data_oe = 0, acks = 0, busy = 0.
  - rdata registers = 0x0000, ADDR = 0, Data_out = 0.
  - An interrupted write leaves memory contents undefined; no ack is issued.
- Request high at IDLE edge t:
  - ACCESS covers cycles t+1 .. t+WAIT_CYCLES.
  - DONE and ack occur in cycle t+WAIT_CYCLES+1.
  - IDLE is at t+WAIT_CYCLES+2.
- Minimum spacing between transactions is WAIT_CYCLES+2 cycles; there are no back-to-back accesses.
- A requester with registered control drops req on the edge after it sees ack. The arbiter samples low in that IDLE cycle, so no duplicate access occurs.
- A request still high in the IDLE cycle after DONE is a new transaction. This is how continuous loader streaming works.
- Simultaneous requests are served alternately: CPU, loader, CPU, ... while both remain high.

## Structure
- Package sram_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - requester enum {REQ_CPU, REQ_LD};
  - the default WAIT_CYCLES constant.
- One sub-module, rr_arb2: a combinational two-way round-robin pick from req[1:0] and `last`. The `last` register stays in sram_arbiter and updates on entry to ACCESS.
- The Data tristate lives at top level, driven by Data_out and Data_oe.

## Test plan
- Reset mid-write: assert Reset low during ACCESS -> all strobes immediately 1, Data_oe 0, busy 0, no ld_ack/cpu_ack.
- CPU write then read, WAIT_CYCLES=2:
  - write 0x1234 to 0x0003 -> WE low exactly 2 cycles, ADDR 0x00003, cpu_ack 3 cycles after the request edge.
  - read 0x0003 -> OE low 2 cycles, cpu_rdata = 0x1234 in the ack cycle.
- Tie after reset: both requests high at the same edge -> CPU served first, loader next, loader's ack 4 cycles after CPU's ack.
- Sustained contention: both requests held high for 6 transactions -> grants alternate C,L,C,L,C,L with WE/OE never low together.
- Loader streaming: ld_req held high, addresses 0..7 -> 8 writes, one every WAIT_CYCLES+2 cycles, busy low for exactly one cycle between them.
- WAIT_CYCLES=1 read: ack 2 cycles after the request edge, ld_rdata captured, cpu_rdata unchanged.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter.
//   state_e : sequencer states (IDLE -> ACCESS -> DONE -> IDLE)
//   req_e   : requester identity, also the encoding of the round-robin history
//   WAIT_CYCLES_DEF : default number of ACCESS cycles per transaction
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LD  = 1'b1
  } req_e;

  localparam int unsigned WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req_i[0]  : CPU request
//   req_i[1]  : loader request
//   last_i    : requester granted most recently
//   gnt_vld_o : at least one request present
//   gnt_id_o  : winning requester (meaningful only when gnt_vld_o is high)
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_e       last_i,
  output logic       gnt_vld_o,
  output req_e       gnt_id_o
);

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_id_o  = REQ_CPU;
    case (req_i)
      2'b01:   gnt_id_o = REQ_CPU;
      2'b10:   gnt_id_o = REQ_LD;
      2'b11: begin
        // On a tie the side that did not win last time goes next.
        if (last_i == REQ_CPU) gnt_id_o = REQ_LD;
        else                   gnt_id_o = REQ_CPU;
      end
      default: gnt_id_o = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Sequencer sharing one 16-bit asynchronous SRAM between the CPU memory path
// and the program loader. Each transaction runs IDLE -> ACCESS (WAIT_CYCLES
// cycles) -> DONE (ack) -> IDLE, so accesses are never back to back.
// Ports:
//   Clk, Reset (async, active-low)
//   cpu_req/we/addr/wdata -> cpu_rdata, cpu_ack   CPU requester
//   ld_req/we/addr/wdata  -> ld_rdata,  ld_ack    loader requester
//   CE, UB, LB, OE, WE    active-low SRAM strobes
//   ADDR                  zero-extended latched word address
//   Data_out, Data_oe     write data and drive enable for the pad tristate
//   Data_in               read data from the pad
//   busy                  high whenever not in IDLE
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [15:0]       ld_addr,
  input  logic [15:0]       ld_wdata,
  output logic [15:0]       ld_rdata,
  output logic              ld_ack,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [15:0]       Data_out,
  output logic              Data_oe,
  input  logic [15:0]       Data_in,
  output logic              busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  req_e        last_q, last_d;
  req_e        id_q, id_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] ld_rdata_q, ld_rdata_d;

  logic gnt_vld;
  req_e gnt_id;

  rr_arb2 u_rr (
    .req_i     ({ld_req, cpu_req}),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      wait_q      <= 4'd0;
      last_q      <= REQ_LD;  // CPU wins the first tie
      id_q        <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
      ld_rdata_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      last_q      <= last_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    last_d      = last_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = ACCESS;
          wait_d  = WAIT_LOAD;
          last_d  = gnt_id;
          id_d    = gnt_id;
          if (gnt_id == REQ_LD) begin
            we_d    = ld_we;
            addr_d  = ld_addr;
            wdata_d = ld_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ACCESS: begin
        if (wait_q == 4'd0) begin
          state_d = DONE;
          // Capture on the last ACCESS edge while OE is still low.
          if (!we_q) begin
            if (id_q == REQ_CPU) cpu_rdata_d = Data_in;
            else                 ld_rdata_d  = Data_in;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic in_acc, in_done;
  assign in_acc  = (state_q == ACCESS);
  assign in_done = (state_q == DONE);

  // Chip select spans DONE so address/data stay qualified after WE/OE rise.
  assign CE       = ~(in_acc | in_done);
  assign UB       = CE;
  assign LB       = CE;
  assign OE       = ~(in_acc & ~we_q);
  assign WE       = ~(in_acc & we_q);
  assign Data_oe  = (in_acc | in_done) & we_q;
  assign Data_out = wdata_q;
  assign ADDR     = ADDR_W'(addr_q);
  assign cpu_ack  = in_done & (id_q == REQ_CPU);
  assign ld_ack   = in_done & (id_q == REQ_LD);
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  typedef struct {
    logic        id;     // 1 = loader
    logic        rd;
    logic [15:0] rdata;
    logic [19:0] addr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset;

  // DUT 0: WAIT_CYCLES = 2
  logic        cpu_req, cpu_we, cpu_ack, ld_req, ld_we, ld_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, ld_addr, ld_wdata, ld_rdata;
  logic        CE, UB, LB, OE, WE, Data_oe, busy;
  logic [19:0] ADDR;
  logic [15:0] Data_out, Data_in;

  // DUT 1: WAIT_CYCLES = 1
  logic        cpu_req1, cpu_we1, cpu_ack1, ld_req1, ld_we1, ld_ack1;
  logic [15:0] cpu_addr1, cpu_wdata1, cpu_rdata1, ld_addr1, ld_wdata1, ld_rdata1;
  logic        CE1, UB1, LB1, OE1, WE1, Data_oe1, busy1;
  logic [19:0] ADDR1;
  logic [15:0] Data_out1, Data_in1;

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR),
    .Data_out(Data_out), .Data_oe(Data_oe), .Data_in(Data_in), .busy(busy)
  );

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
    .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
    .ld_req(ld_req1), .ld_we(ld_we1), .ld_addr(ld_addr1), .ld_wdata(ld_wdata1),
    .ld_rdata(ld_rdata1), .ld_ack(ld_ack1),
    .CE(CE1), .UB(UB1), .LB(LB1), .OE(OE1), .WE(WE1), .ADDR(ADDR1),
    .Data_out(Data_out1), .Data_oe(Data_oe1), .Data_in(Data_in1), .busy(busy1)
  );

  // Behavioural SRAMs (low 8 address bits are enough for the vectors used).
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  always @(posedge Clk) if (!CE && !WE && Data_oe) mem0[ADDR[7:0]] <= Data_out;
  always @(posedge Clk) if (!CE1 && !WE1 && Data_oe1) mem1[ADDR1[7:0]] <= Data_out1;
  assign Data_in  = !OE  ? mem0[ADDR[7:0]]  : 16'h0000;
  assign Data_in1 = !OE1 ? mem1[ADDR1[7:0]] : 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within its cycle budget", nm);
  endtask

  // Scoreboard monitors: pop one expectation per ack.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset && (cpu_ack || ld_ack)) begin
      if (q0.size() == 0) fail_now("sb0_unexpected_ack");
      else begin
        e = q0.pop_front();
        chk("sb0_single_ack", {31'd0, cpu_ack & ld_ack}, 32'd0);
        chk("sb0_ack_port", {31'd0, ld_ack}, {31'd0, e.id});
        chk("sb0_addr", {12'd0, ADDR}, {12'd0, e.addr});
        if (e.rd) chk("sb0_rdata", {16'd0, e.id ? ld_rdata : cpu_rdata}, {16'd0, e.rdata});
      end
    end
    if (Reset && busy) begin
      chk("sb0_oe_we_excl", {31'd0, OE | WE}, 32'd1);
      chk("sb0_ce_ub_lb", {29'd0, CE, UB, LB}, 32'd0);
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    if (Reset && (cpu_ack1 || ld_ack1)) begin
      if (q1.size() == 0) fail_now("sb1_unexpected_ack");
      else begin
        e = q1.pop_front();
        chk("sb1_ack_port", {31'd0, ld_ack1}, {31'd0, e.id});
        chk("sb1_addr", {12'd0, ADDR1}, {12'd0, e.addr});
        if (e.rd) chk("sb1_rdata", {16'd0, e.id ? ld_rdata1 : cpu_rdata1}, {16'd0, e.rdata});
      end
    end
    if (Reset && busy1) begin
      chk("sb1_oe_we_excl", {31'd0, OE1 | WE1}, 32'd1);
      chk("sb1_ce_ub_lb", {29'd0, CE1, UB1, LB1}, 32'd0);
    end
  end

  // One transaction on DUT 0; n counts cycles from the request edge.
  task automatic txn0(input logic ld, input logic we, input logic [15:0] a, input logic [15:0] wd,
                      output int ack_n, output int we_n, output int oe_n, output logic [19:0] addr_seen);
    @(posedge Clk); #1;
    if (ld) begin ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = wd; end
    else    begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    ack_n = -1; we_n = 0; oe_n = 0; addr_seen = '0;
    for (int n = 0; n < 12 && ack_n < 0; n++) begin
      @(negedge Clk);
      if (!WE) we_n++;
      if (!OE) oe_n++;
      if (n == 1) addr_seen = ADDR;
      if (ld ? ld_ack : cpu_ack) ack_n = n;
    end
    @(posedge Clk); #1;
    cpu_req = 0; ld_req = 0;
    if (ack_n < 0) fail_now("txn0_ack_timeout");
  endtask

  task automatic txn1(input logic ld, input logic we, input logic [15:0] a, input logic [15:0] wd,
                      output int ack_n, output int oe_n);
    @(posedge Clk); #1;
    if (ld) begin ld_req1 = 1; ld_we1 = we; ld_addr1 = a; ld_wdata1 = wd; end
    else    begin cpu_req1 = 1; cpu_we1 = we; cpu_addr1 = a; cpu_wdata1 = wd; end
    ack_n = -1; oe_n = 0;
    for (int n = 0; n < 12 && ack_n < 0; n++) begin
      @(negedge Clk);
      if (!OE1) oe_n++;
      if (ld ? ld_ack1 : cpu_ack1) ack_n = n;
    end
    @(posedge Clk); #1;
    cpu_req1 = 0; ld_req1 = 0;
    if (ack_n < 0) fail_now("txn1_ack_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_n, we_n, oe_n, cn, ln, k, prev, idle_cnt;
    logic [19:0] aseen;
    Reset = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    cpu_req1 = 0; cpu_we1 = 0; cpu_addr1 = 0; cpu_wdata1 = 0;
    ld_req1 = 0; ld_we1 = 0; ld_addr1 = 0; ld_wdata1 = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1F);
    chk("rst_data_oe", {31'd0, Data_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, cpu_ack, ld_ack}, 32'd0);
    chk("rst_addr", {12'd0, ADDR}, 32'd0);
    chk("rst_rdata", {cpu_rdata, ld_rdata}, 32'd0);
    chk("rst_dout", {16'd0, Data_out}, 32'd0);
    @(posedge Clk); #1 Reset = 1;

    // CPU write 0x1234 -> 0x0003, then read it back.
    q0.push_back('{id: 1'b0, rd: 1'b0, rdata: 16'h0, addr: 20'h00003});
    txn0(1'b0, 1'b1, 16'h0003, 16'h1234, ack_n, we_n, oe_n, aseen);
    chk("wr_ack_latency", ack_n, 3);
    chk("wr_we_cycles", we_n, 2);
    chk("wr_oe_cycles", oe_n, 0);
    chk("wr_addr", {12'd0, aseen}, 32'h00003);
    q0.push_back('{id: 1'b0, rd: 1'b1, rdata: 16'h1234, addr: 20'h00003});
    txn0(1'b0, 1'b0, 16'h0003, 16'h0000, ack_n, we_n, oe_n, aseen);
    chk("rd_ack_latency", ack_n, 3);
    chk("rd_oe_cycles", oe_n, 2);
    chk("rd_we_cycles", we_n, 0);
    chk("rd_cpu_rdata_held", {16'd0, cpu_rdata}, 32'h1234);
    chk("rd_ld_rdata_unchanged", {16'd0, ld_rdata}, 32'h0);

    // Reset asserted in the middle of a loader write.
    @(posedge Clk); #1;
    ld_req = 1; ld_we = 1; ld_addr = 16'h0005; ld_wdata = 16'h5555;
    @(posedge Clk);
    @(negedge Clk);
    chk("midwr_we_low", {31'd0, WE}, 32'd0);
    #2 Reset = 0;
    #1;
    chk("midwr_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1F);
    chk("midwr_data_oe", {31'd0, Data_oe}, 32'd0);
    chk("midwr_busy", {31'd0, busy}, 32'd0);
    chk("midwr_acks", {30'd0, cpu_ack, ld_ack}, 32'd0);
    chk("midwr_rdata", {16'd0, cpu_rdata}, 32'd0);
    ld_req = 0;
    @(posedge Clk); #1 Reset = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("midwr_no_ack", {30'd0, cpu_ack, ld_ack}, 32'd0);
    end

    // Tie right after reset: CPU first, loader 4 cycles later.
    q0.push_back('{id: 1'b0, rd: 1'b0, rdata: 16'h0, addr: 20'h00020});
    q0.push_back('{id: 1'b1, rd: 1'b0, rdata: 16'h0, addr: 20'h00021});
    @(posedge Clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'hC0C0;
    ld_req = 1;  ld_we = 1;  ld_addr = 16'h0021;  ld_wdata = 16'h1D1D;
    cn = -1; ln = -1;
    for (int n = 0; n < 20 && ln < 0; n++) begin
      @(negedge Clk);
      if (cpu_ack) cn = n;
      if (ld_ack) ln = n;
      @(posedge Clk); #1;
      if (cn == n) cpu_req = 0;
      if (ln == n) ld_req = 0;
    end
    cpu_req = 0; ld_req = 0;
    chk("tie_cpu_ack", cn, 3);
    chk("tie_ld_ack", ln, 7);

    // Sustained contention: six reads alternating C,L,C,L,C,L.
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{id: 1'b0, rd: 1'b1, rdata: 16'hC0C0, addr: 20'h00020});
      q0.push_back('{id: 1'b1, rd: 1'b1, rdata: 16'h1D1D, addr: 20'h00021});
    end
    @(posedge Clk); #1;
    cpu_req = 1; cpu_we = 0; ld_req = 1; ld_we = 0;
    k = 0; prev = 0;
    for (int n = 0; n < 60 && k < 6; n++) begin
      @(negedge Clk);
      if (cpu_ack || ld_ack) begin
        if (k > 0) chk("cont_spacing", n - prev, 4);
        prev = n;
        k++;
      end
      @(posedge Clk); #1;
      if (k == 6) begin cpu_req = 0; ld_req = 0; end
    end
    cpu_req = 0; ld_req = 0;
    if (k < 6) fail_now("cont_ack_timeout");

    // Loader streaming: addresses 0..7 with req held high throughout.
    for (int i = 0; i < 8; i++)
      q0.push_back('{id: 1'b1, rd: 1'b0, rdata: 16'h0, addr: 20'(i)});
    @(posedge Clk); #1;
    ld_req = 1; ld_we = 1; ld_addr = 16'h0000; ld_wdata = 16'h5000;
    k = 0; prev = 0; idle_cnt = 0;
    for (int n = 0; n < 100 && k < 8; n++) begin
      @(negedge Clk);
      if (!busy) idle_cnt++;
      if (ld_ack) begin
        if (k > 0) begin
          chk("stream_spacing", n - prev, 4);
          chk("stream_idle_gap", idle_cnt, 1);
        end
        prev = n;
        idle_cnt = 0;
        k++;
        @(posedge Clk); #1;
        if (k == 8) ld_req = 0;
        else begin ld_addr = 16'(k); ld_wdata = 16'h5000 + 16'(k); end
      end
    end
    ld_req = 0;
    if (k < 8) fail_now("stream_ack_timeout");

    // Read back the first and last streamed words.
    q0.push_back('{id: 1'b0, rd: 1'b1, rdata: 16'h5000, addr: 20'h00000});
    txn0(1'b0, 1'b0, 16'h0000, 16'h0, ack_n, we_n, oe_n, aseen);
    q0.push_back('{id: 1'b0, rd: 1'b1, rdata: 16'h5007, addr: 20'h00007});
    txn0(1'b0, 1'b0, 16'h0007, 16'h0, ack_n, we_n, oe_n, aseen);
    chk("readback_ack_latency", ack_n, 3);

    // WAIT_CYCLES = 1 instance.
    q1.push_back('{id: 1'b0, rd: 1'b0, rdata: 16'h0, addr: 20'h00009});
    txn1(1'b0, 1'b1, 16'h0009, 16'h4444, ack_n, oe_n);
    chk("w1_wr_ack_latency", ack_n, 2);
    q1.push_back('{id: 1'b1, rd: 1'b0, rdata: 16'h0, addr: 20'h00042});
    txn1(1'b1, 1'b1, 16'h0042, 16'hBEEF, ack_n, oe_n);
    q1.push_back('{id: 1'b0, rd: 1'b1, rdata: 16'h4444, addr: 20'h00009});
    txn1(1'b0, 1'b0, 16'h0009, 16'h0, ack_n, oe_n);
    q1.push_back('{id: 1'b1, rd: 1'b1, rdata: 16'hBEEF, addr: 20'h00042});
    txn1(1'b1, 1'b0, 16'h0042, 16'h0, ack_n, oe_n);
    chk("w1_rd_ack_latency", ack_n, 2);
    chk("w1_rd_oe_cycles", oe_n, 1);
    chk("w1_ld_rdata", {16'd0, ld_rdata1}, 32'hBEEF);
    chk("w1_cpu_rdata_unchanged", {16'd0, cpu_rdata1}, 32'h4444);

    repeat (3) @(posedge Clk);
    chk("sb0_queue_drained", q0.size(), 0);
    chk("sb1_queue_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
